// File: rtl/cic_decim_backend.sv
// CIC decimator back end: keep every rate-th valid sample, then CIC_N comb stages.
// Optional runtime rate loading is enabled by defining CIC_VARIABLE_RATE_EN.
module cic_decim_backend #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CIC_R      = 10,
  parameter int unsigned CIC_M      = 1,
  parameter int unsigned CIC_N      = 7,
  parameter int unsigned RATE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_axis_in_tdata,
  input  logic                  s_axis_in_tvalid,
  input  logic [RATE_WIDTH-1:0] s_axis_rate_tdata,
  input  logic                  s_axis_rate_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_out_tdata,
  output logic                  m_axis_out_tvalid
);

  localparam int unsigned CNT_W = $clog2(CIC_R + 1);

  logic [CNT_W-1:0]             cnt;
  logic signed [DATA_WIDTH-1:0] ds_data;
  logic                         ds_valid;
  logic                         cnt_wrap_c;

`ifdef CIC_VARIABLE_RATE_EN
  logic [CNT_W-1:0] rate_q;
  logic [CNT_W-1:0] rate_load_c;

  // Requested rate clamped into 1..CIC_R
  always_comb begin
    rate_load_c = CNT_W'(CIC_R);
    if (s_axis_rate_tdata == '0) begin
      rate_load_c = CNT_W'(1);
    end else if (32'(s_axis_rate_tdata) <= 32'(CIC_R)) begin
      rate_load_c = CNT_W'(s_axis_rate_tdata);
    end
  end

  assign cnt_wrap_c = (cnt == rate_q - CNT_W'(1));
`else
  logic unused_rate;
  assign unused_rate = ^{s_axis_rate_tdata, s_axis_rate_tvalid};
  assign cnt_wrap_c  = (cnt == CNT_W'(CIC_R - 1));
`endif

  // Downsampler: registers the rate-th valid sample and pulses ds_valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      ds_data  <= '0;
      ds_valid <= 1'b0;
`ifdef CIC_VARIABLE_RATE_EN
      rate_q   <= CNT_W'(CIC_R);
`endif
    end else begin
      ds_valid <= 1'b0;
`ifdef CIC_VARIABLE_RATE_EN
      if (s_axis_rate_tvalid) begin
        rate_q <= rate_load_c;
        cnt    <= '0;
      end else
`endif
      if (s_axis_in_tvalid) begin
        if (cnt_wrap_c) begin
          cnt      <= '0;
          ds_data  <= s_axis_in_tdata;
          ds_valid <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < CIC_N; k++) begin : g_comb
    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] dout;
    logic                         dvalid;
    logic signed [DATA_WIDTH-1:0] dly [CIC_M];

    if (k == 0) begin : g_first
      assign in_data  = ds_data;
      assign in_valid = ds_valid;
    end else begin : g_chain
      assign in_data  = g_comb[k-1].dout;
      assign in_valid = g_comb[k-1].dvalid;
    end

    // y[n] = x[n] - x[n-CIC_M], evaluated only on valid samples
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        dout   <= '0;
        dvalid <= 1'b0;
        for (int i = 0; i < int'(CIC_M); i++) begin
          dly[i] <= '0;
        end
      end else begin
        dvalid <= in_valid;
        if (in_valid) begin
          dout   <= in_data - dly[CIC_M-1];
          dly[0] <= in_data;
          for (int i = 1; i < int'(CIC_M); i++) begin
            dly[i] <= dly[i-1];
          end
        end
      end
    end
  end

  assign m_axis_out_tdata  = g_comb[CIC_N-1].dout;
  assign m_axis_out_tvalid = g_comb[CIC_N-1].dvalid;

endmodule

// File: tb/tb_cic_decim_backend.sv
// Scoreboard bench for cic_decim_backend: a 2-stage R=4 instance and a 1-stage R=1 wrap instance.
module tb_cic_decim_backend;

  localparam int unsigned DW = 16;
  localparam int unsigned R  = 4;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clk;
  logic          reset;
  logic [DW-1:0] in_tdata;
  logic          in_tvalid;
  logic [15:0]   rate_tdata;
  logic          rate_tvalid;
  logic [DW-1:0] out_tdata;
  logic          out_tvalid;
  logic [DW-1:0] in1_tdata;
  logic          in1_tvalid;
  logic [15:0]   rate1_tdata;
  logic          rate1_tvalid;
  logic [DW-1:0] out1_tdata;
  logic          out1_tvalid;

  int   tests;
  int   fails;
  int   cyc;
  exp_t exp0[$];
  exp_t exp1[$];

  // Reference model state
  int               m_cnt;
  int               m_rate;
  logic signed [DW-1:0] m_d1, m_d2, m1_d;

  cic_decim_backend #(.DATA_WIDTH(DW), .CIC_R(R), .CIC_M(1), .CIC_N(2), .RATE_WIDTH(16)) u_dut (
    .clk(clk), .reset(reset),
    .s_axis_in_tdata(in_tdata), .s_axis_in_tvalid(in_tvalid),
    .s_axis_rate_tdata(rate_tdata), .s_axis_rate_tvalid(rate_tvalid),
    .m_axis_out_tdata(out_tdata), .m_axis_out_tvalid(out_tvalid)
  );

  cic_decim_backend #(.DATA_WIDTH(DW), .CIC_R(1), .CIC_M(1), .CIC_N(1), .RATE_WIDTH(16)) u_dut1 (
    .clk(clk), .reset(reset),
    .s_axis_in_tdata(in1_tdata), .s_axis_in_tvalid(in1_tvalid),
    .s_axis_rate_tdata(rate1_tdata), .s_axis_rate_tvalid(rate1_tvalid),
    .m_axis_out_tdata(out1_tdata), .m_axis_out_tvalid(out1_tvalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic monitor_outputs();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (out_tvalid) begin
          tests++;
          if (exp0.size() == 0) begin
            fails++;
            $display("FAIL out0_unexpected: got data %0d at cycle %0d, expected no output", $signed(out_tdata), cyc);
          end else begin
            e = exp0.pop_front();
            if (out_tdata !== e.data || cyc !== e.cyc) begin
              fails++;
              $display("FAIL out0_sample: got %0d at cycle %0d, expected %0d at cycle %0d",
                       $signed(out_tdata), cyc, $signed(e.data), e.cyc);
            end
          end
        end
        if (out1_tvalid) begin
          tests++;
          if (exp1.size() == 0) begin
            fails++;
            $display("FAIL out1_unexpected: got data %0d at cycle %0d, expected no output", $signed(out1_tdata), cyc);
          end else begin
            e = exp1.pop_front();
            if (out1_tdata !== e.data || cyc !== e.cyc) begin
              fails++;
              $display("FAIL out1_sample: got %0d at cycle %0d, expected %0d at cycle %0d",
                       $signed(out1_tdata), cyc, $signed(e.data), e.cyc);
            end
          end
        end
      end
    end
  endtask

  task automatic count_cycles();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  // One cycle of stimulus on the R=4 instance; the model predicts any output it causes
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic ld, input logic [15:0] r);
    logic signed [DW-1:0] x, y1, y2;
    @(negedge clk);
    in_tvalid   = v;
    in_tdata    = d;
    rate_tvalid = ld;
    rate_tdata  = r;
    x = d;
`ifdef CIC_VARIABLE_RATE_EN
    if (ld) begin
      m_rate = (r == 16'd0) ? 1 : ((int'(r) > int'(R)) ? int'(R) : int'(r));
      m_cnt  = 0;
    end else
`endif
    if (v) begin
      if (m_cnt == m_rate - 1) begin
        m_cnt = 0;
        y1    = x - m_d1;
        m_d1  = x;
        y2    = y1 - m_d2;
        m_d2  = y1;
        exp0.push_back('{data: y2, cyc: cyc + 3});
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic drive1(input logic v, input logic [DW-1:0] d);
    logic signed [DW-1:0] x, y;
    @(negedge clk);
    in1_tvalid = v;
    in1_tdata  = d;
    x = d;
    if (v) begin
      y    = x - m1_d;
      m1_d = x;
      exp1.push_back('{data: y, cyc: cyc + 2});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, '0, 1'b0, 16'd0);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (exp0.size() == 0 && exp1.size() == 0) break;
      idle(1);
    end
    tests++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d/%0d outputs still pending, expected 0/0", name, exp0.size(), exp1.size());
      exp0.delete();
      exp1.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_tvalid = 1'b0; rate_tvalid = 1'b0; in1_tvalid = 1'b0;
    exp0.delete();
    exp1.delete();
    m_cnt = 0; m_rate = int'(R); m_d1 = '0; m_d2 = '0; m1_d = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_tvalid = 1'b0; in_tdata = '0; rate_tvalid = 1'b0; rate_tdata = '0;
    in1_tvalid = 1'b0; in1_tdata = '0; rate1_tvalid = 1'b0; rate1_tdata = '0;
    m_cnt = 0; m_rate = int'(R); m_d1 = '0; m_d2 = '0; m1_d = '0;
    repeat (2) @(negedge clk);
    tests += 4;
    if (out_tdata !== '0)   begin fails++; $display("FAIL reset_data0: got %0d, expected 0", out_tdata); end
    if (out_tvalid !== 1'b0) begin fails++; $display("FAIL reset_valid0: got %b, expected 0", out_tvalid); end
    if (out1_tdata !== '0)  begin fails++; $display("FAIL reset_data1: got %0d, expected 0", out1_tdata); end
    if (out1_tvalid !== 1'b0) begin fails++; $display("FAIL reset_valid1: got %b, expected 0", out1_tvalid); end
    reset = 1'b0;
  endtask

  task automatic test_constant();
    do_reset();
    for (int i = 0; i < 16; i++) drive(1'b1, DW'(5), 1'b0, 16'd0);
    wait_drain("constant");
  endtask

  task automatic test_ramp();
    do_reset();
    for (int i = 0; i < 16; i++) drive(1'b1, DW'(i), 1'b0, 16'd0);
    wait_drain("ramp");
  endtask

  task automatic test_every_other();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, DW'(i), 1'b0, 16'd0);
      drive(1'b0, '0, 1'b0, 16'd0);
    end
    wait_drain("every_other");
  endtask

  task automatic test_wrap();
    do_reset();
    drive1(1'b1, DW'(32767));
    drive1(1'b1, DW'(-32768));
    drive1(1'b0, '0);
    wait_drain("wrap");
  endtask

  task automatic test_midstream_reset();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, DW'(5), 1'b0, 16'd0);
    idle(4);
    drive(1'b1, DW'(0), 1'b0, 16'd0);
    drive(1'b1, DW'(1), 1'b0, 16'd0);
    @(negedge clk);
    reset = 1'b1;
    in_tvalid = 1'b0;
    #1;
    tests += 2;
    if (out_tdata !== '0)    begin fails++; $display("FAIL midreset_data: got %0d, expected 0", out_tdata); end
    if (out_tvalid !== 1'b0) begin fails++; $display("FAIL midreset_valid: got %b, expected 0", out_tvalid); end
    @(negedge clk);
    exp0.delete();
    m_cnt = 0; m_d1 = '0; m_d2 = '0;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) drive(1'b1, DW'(i), 1'b0, 16'd0);
    wait_drain("midreset");
  endtask

`ifdef CIC_VARIABLE_RATE_EN
  task automatic test_variable_rate();
    do_reset();
    drive(1'b0, '0, 1'b1, 16'd2);
    for (int i = 0; i < 8; i++) drive(1'b1, DW'(i), 1'b0, 16'd0);
    wait_drain("rate2");
    drive(1'b0, '0, 1'b1, 16'd0);
    for (int i = 0; i < 6; i++) drive(1'b1, DW'(i * 3), 1'b0, 16'd0);
    wait_drain("rate0");
    drive(1'b0, '0, 1'b1, 16'd100);
    for (int i = 0; i < 12; i++) drive(1'b1, DW'(i), 1'b0, 16'd0);
    wait_drain("rate100");
    drive(1'b1, DW'(2), 1'b0, 16'd0);
    drive(1'b1, DW'(50), 1'b1, 16'd3);
    for (int i = 0; i < 9; i++) drive(1'b1, DW'(i + 7), 1'b0, 16'd0);
    wait_drain("rate_coincident");
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    fork
      monitor_outputs();
      count_cycles();
    join_none
    test_reset();
    test_constant();
    test_ramp();
    test_every_other();
    test_wrap();
    test_midstream_reset();
`ifdef CIC_VARIABLE_RATE_EN
    test_variable_rate();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cic_decim_backend.md
Name: cic_decim_backend

Overview:
- Back half of a CIC decimator: a sample-rate downsampler followed by a chain of CIC_N comb stages.
- It receives integrator-chain output as an AXI-Stream-like valid/data stream.
- It keeps every R-th valid sample, then applies y[n] = x[n] - x[n-CIC_M] CIC_N times at the decimated rate.
- It sits between the integrator chain and the output register of the CIC decimator.

Parameters:
- DATA_WIDTH, 32: width of input, internal and output samples (two's complement, signed).
- CIC_R, 10: decimation ratio. With variable rate enabled, this is the reset/maximum rate. Must be >= 1.
- CIC_M, 1: differential delay of each comb stage. Must be >= 1.
- CIC_N, 7: number of comb stages. Must be >= 1.
- RATE_WIDTH, 16: width of the rate input.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_axis_in_tdata  in  DATA_WIDTH  signed input sample.
- s_axis_in_tvalid  in  1  input sample strobe, one sample per asserted cycle.
- s_axis_rate_tdata  in  RATE_WIDTH  unsigned new decimation ratio.
- s_axis_rate_tvalid  in  1  rate load strobe.
- m_axis_out_tdata  out  DATA_WIDTH  signed output sample.
- m_axis_out_tvalid  out  1  one-cycle output strobe.

Behaviour:
- No backpressure. Every asserted tvalid is consumed the same cycle.
- Reset state: all data registers, comb delay lines and counters are 0; m_axis_out_tvalid = 0; m_axis_out_tdata = 0; active rate = CIC_R.
- Reset is effective immediately, including mid-stream; partial decimation counts are discarded.
- Downsampler counter cnt:
  - Counts valid inputs from 0 to rate-1.
  - On an input valid with cnt == rate-1: register the sample, pulse ds_valid for 1 cycle, set cnt = 0.
  - Otherwise on an input valid: cnt = cnt + 1.
  - The first output is the rate-th valid sample after reset.
- Downsampler output is registered: ds_valid is asserted the cycle after the accepted input. ds_valid is a single-cycle pulse; data holds until the next output.
- Comb stage k (k = 0..CIC_N-1):
  - Input is the downsampler output for k = 0, else the output of stage k-1.
  - On input valid: out <= in - delay[CIC_M-1], shift in into the CIC_M-deep delay line, out_valid <= 1.
  - Otherwise: out_valid <= 0 and data holds.
  - Latency is 1 cycle per stage.
- Arithmetic is full DATA_WIDTH two's complement, with modulo wrap-around and no saturation or growth.
- Output: m_axis_out_tdata/m_axis_out_tvalid are the last comb stage registers.
- Total latency from accepting the rate-th input to m_axis_out_tvalid is CIC_N+1 cycles.
- Input valid on back-to-back cycles is supported at any rate, including rate 1.

Optional Feature:
- Macro CIC_VARIABLE_RATE_EN.
- Defined:
  - When s_axis_rate_tvalid is high, active rate <= s_axis_rate_tdata, clamped so that 0 is treated as 1 and values > CIC_R become CIC_R.
  - cnt is cleared to 0 on the load.
  - A rate load has priority over a same-cycle input valid: that input sample is not counted and produces no output.
  - Comb delay lines are not cleared on a rate change.
- Undefined:
  - Rate is fixed at CIC_R.
  - s_axis_rate_tdata/s_axis_rate_tvalid are present but ignored.
  - Counter compare uses the constant CIC_R-1.

Test Plan:
- Fixed rate, DATA_WIDTH=16, CIC_R=4, CIC_M=1, CIC_N=2; constant input 5 every cycle -> outputs 5, -5, 0, 0, ...; first m_axis_out_tvalid exactly 3 cycles after the 4th input valid; tvalid is 1 cycle wide, every 4 cycles.
- Same config, ramp input 0,1,2,... every cycle -> decimated samples 3, 7, 11, 15; outputs 3, 1, 0, 0.
- Same config, input valid asserted every other cycle, ramp -> identical output values; outputs spaced 8 cycles.
- Wrap-around, CIC_N=1, CIC_R=1: inputs 32767 then -32768 -> outputs 32767 then 1; no saturation.
- Reset mid-stream: after 2 of 4 inputs, pulse reset -> outputs 0 / valid 0 immediately; a subsequent ramp starting at 0 yields outputs 3, 1, 0, ... as in the ramp test.
- CIC_VARIABLE_RATE_EN: load rate 2 then ramp 0,1,2,... -> decimated samples 1, 3, 5, 7; outputs 1, 1, 0, 0. Load rate 0 -> every sample passes. Load 100 -> behaves as CIC_R=4. Rate load coincident with an input valid -> that sample is ignored and the count restarts.
